pwm_ramp_controller: RTL and testbench

Sequencing controller for the PWM datapath. It accepts a target on-time through a valid/ready handshake and ramps the applied duty toward that target in bounded steps. Duty changes only at PWM period boundaries. It owns the period counter, drives pwm_out directly, and exports the applied duty and a period tick so other blocks can synchronise. It is used for soft-start/soft-stop of loads behind the PWM output.

---
 rtl/pwm_ramp_controller.sv | 111 +++++++++++
 tb/tb_pwm_ramp_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// PWM generator with a period counter and a soft-start/soft-stop duty ramp.
// Duty is stepped toward a handshaked target only at period boundaries, so every period uses one duty value.
module pwm_ramp_controller #(
    parameter int PERIOD = 100,
    parameter int WIDTH  = 8,
    parameter int STEP   = 1,
    parameter int DIVIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] tgt_duty,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             ramping,
    output logic             done
);

    localparam int DIV_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVIDE - 1);
    localparam logic [WIDTH-1:0] PERIOD_W  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] PERIOD_M1 = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] target_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             done_q;

    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] duty_d;
    logic [WIDTH:0]   duty_ext;
    logic [WIDTH:0]   tgt_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   stepped;
    logic             up;

    assign period_tick = en & (cnt_q == PERIOD_M1);
    assign pwm_out     = en & (cnt_q < duty_q);
    assign tgt_ready   = (state_q != RAMP);
    assign ramping     = (state_q == RAMP);
    assign duty        = duty_q;
    assign done        = done_q;

    assign clamped = (tgt_duty > PERIOD_W) ? PERIOD_W : tgt_duty;

    // One extra bit keeps the step arithmetic from wrapping at either end of the range.
    always_comb begin
        duty_ext = {1'b0, duty_q};
        tgt_ext  = {1'b0, target_q};
        up       = tgt_ext > duty_ext;
        diff     = up ? (tgt_ext - duty_ext) : (duty_ext - tgt_ext);
        stepped  = up ? (duty_ext + STEP_W) : (duty_ext - STEP_W);
        duty_d   = (diff <= STEP_W) ? target_q : stepped[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            duty_q    <= '0;
            target_q  <= '0;
            div_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (!en || cnt_q == PERIOD_M1) cnt_q <= '0;
            else                           cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE, HOLD: begin
                    if (tgt_valid) begin
                        target_q <= clamped;
                        if (clamped == duty_q) begin
                            state_q <= HOLD;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RAMP;
                            div_cnt_q <= '0;
                        end
                    end
                end
                RAMP: begin
                    // Duty changes on the wrap edge, so a period never sees two duty values.
                    if (period_tick) begin
                        if (div_cnt_q == DIV_LAST) begin
                            div_cnt_q <= '0;
                            duty_q    <= duty_d;
                            if (duty_d == target_q) begin
                                state_q <= HOLD;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            div_cnt_q <= div_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench: instance a uses default parameters, instance b uses STEP=10 and DIVIDE=2.
module tb_pwm_ramp_controller;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         a_en = 1'b0, a_tv = 1'b0;
    logic [W-1:0] a_td = '0;
    logic         a_rdy, a_pwm, a_tick, a_rmp, a_done;
    logic [W-1:0] a_duty;

    logic         b_en = 1'b0, b_tv = 1'b0;
    logic [W-1:0] b_td = '0;
    logic         b_rdy, b_pwm, b_tick, b_rmp, b_done;
    logic [W-1:0] b_duty;

    int total = 0;
    int bad = 0;

    pwm_ramp_controller u_a (
        .clk(clk), .reset(reset), .en(a_en), .tgt_duty(a_td), .tgt_valid(a_tv),
        .tgt_ready(a_rdy), .duty(a_duty), .pwm_out(a_pwm), .period_tick(a_tick),
        .ramping(a_rmp), .done(a_done)
    );

    pwm_ramp_controller #(.STEP(10), .DIVIDE(2)) u_b (
        .clk(clk), .reset(reset), .en(b_en), .tgt_duty(b_td), .tgt_valid(b_tv),
        .tgt_ready(b_rdy), .duty(b_duty), .pwm_out(b_pwm), .period_tick(b_tick),
        .ramping(b_rmp), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick_a(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_tick && n < 400);
        if (!a_tick) chk("a_tick_timeout", a_tick, 1);
    endtask

    task automatic wait_tick_b(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!b_tick && n < 400);
        if (!b_tick) chk("b_tick_timeout", b_tick, 1);
    endtask

    task automatic step_a(input int exp, input string tag);
        int n;
        wait_tick_a(n);
        @(negedge clk);
        chk(tag, a_duty, exp);
    endtask

    // DIVIDE=2: first tick only advances the divider, second tick steps duty.
    task automatic step_b(input int prev, input int exp, input string tag);
        int n;
        wait_tick_b(n);
        @(negedge clk);
        chk({tag, "_hold"}, b_duty, prev);
        wait_tick_b(n);
        @(negedge clk);
        chk(tag, b_duty, exp);
    endtask

    initial begin
        int n, cnt_hi, viol, prev;

        // reset values
        @(negedge clk);
        chk("rst_duty", a_duty, 0);
        chk("rst_pwm", a_pwm, 0);
        chk("rst_tick", a_tick, 0);
        chk("rst_ramping", a_rmp, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ready", a_rdy, 1);
        reset = 1'b1;

        // soft start 0 -> 5, step 1
        a_en = 1'b1; a_tv = 1'b1; a_td = 8'd5;
        @(negedge clk);
        a_tv = 1'b0;
        chk("t1_ramping", a_rmp, 1);
        chk("t1_ready", a_rdy, 0);
        for (int k = 1; k <= 5; k++) begin
            step_a(k, $sformatf("t1_step%0d", k));
            if (k < 5) chk($sformatf("t1_nodone%0d", k), a_done, 0);
        end
        chk("t1_done", a_done, 1);
        chk("t1_ramp_fall", a_rmp, 0);
        cnt_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_pwm) cnt_hi++;
            @(negedge clk);
        end
        chk("t1_pwm_hi", cnt_hi, 5);
        chk("t1_done_once", a_done, 0);

        // target held during ramp is ignored until ready returns
        a_tv = 1'b1; a_td = 8'd8;
        @(negedge clk);
        a_td = 8'd20;
        chk("t4_ramping", a_rmp, 1);
        chk("t4_ready", a_rdy, 0);
        step_a(6, "t4_step6");
        step_a(7, "t4_step7");
        chk("t4_ready_mid", a_rdy, 0);
        step_a(8, "t4_step8");
        chk("t4_done", a_done, 1);
        chk("t4_ready_hold", a_rdy, 1);
        @(negedge clk);
        a_tv = 1'b0;
        chk("t4_reaccept", a_rmp, 1);
        chk("t4_done_clr", a_done, 0);
        step_a(9, "t4_step9");
        step_a(10, "t4_step10");

        // pause with en=0, then resume from cnt=0
        a_en = 1'b0;
        viol = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (a_pwm !== 1'b0 || a_tick !== 1'b0) viol++;
        end
        chk("t5_quiet", viol, 0);
        chk("t5_duty_held", a_duty, 10);
        chk("t5_still_ramp", a_rmp, 1);
        a_en = 1'b1;
        wait_tick_a(n);
        chk("t5_resume_lat", n, 99);
        @(negedge clk);
        chk("t5_resume_step", a_duty, 11);

        // asynchronous reset between edges
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_duty", a_duty, 0);
        chk("t6_pwm", a_pwm, 0);
        chk("t6_ramping", a_rmp, 0);
        chk("t6_ready", a_rdy, 1);
        chk("t6_done", a_done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (250) @(negedge clk);
        chk("t6_no_resid_duty", a_duty, 0);
        chk("t6_no_resid_ramp", a_rmp, 0);
        a_tv = 1'b1; a_td = 8'd0;
        @(negedge clk);
        a_tv = 1'b0;
        chk("t6_eq_done", a_done, 1);
        chk("t6_eq_noramp", a_rmp, 0);

        // STEP=10 ramp up with no overshoot
        b_en = 1'b1; b_tv = 1'b1; b_td = 8'd95;
        @(negedge clk);
        b_tv = 1'b0;
        chk("t2_ramping", b_rmp, 1);
        for (int v = 10; v <= 90; v += 10) step_b(v - 10, v, $sformatf("t2_up%0d", v));
        step_b(90, 95, "t2_up95");
        chk("t2_up_done", b_done, 1);

        // ramp down to 3
        b_tv = 1'b1; b_td = 8'd3;
        @(negedge clk);
        b_tv = 1'b0;
        for (int v = 85; v >= 5; v -= 10) step_b(v + 10, v, $sformatf("t2_dn%0d", v));
        step_b(5, 3, "t2_dn3");
        chk("t2_dn_done", b_done, 1);

        // clamp 200 -> 100
        b_tv = 1'b1; b_td = 8'd200;
        @(negedge clk);
        b_tv = 1'b0;
        prev = 3;
        for (int v = 13; v <= 93; v += 10) begin
            step_b(prev, v, $sformatf("t3_up%0d", v));
            prev = v;
        end
        step_b(93, 100, "t3_up100");
        chk("t3_done", b_done, 1);
        cnt_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (b_pwm) cnt_hi++;
            @(negedge clk);
        end
        chk("t3_pwm_full", cnt_hi, 100);

        // target equal to duty: done with no ramp
        b_tv = 1'b1; b_td = 8'd100;
        @(negedge clk);
        b_tv = 1'b0;
        chk("t3_eq_done", b_done, 1);
        chk("t3_eq_noramp", b_rmp, 0);
        chk("t3_eq_ready", b_rdy, 1);
        @(negedge clk);
        chk("t3_eq_done_clr", b_done, 0);
        chk("t3_eq_duty", b_duty, 100);

        // transfer landing on a tick does not step on that tick
        wait_tick_b(n);
        b_tv = 1'b1; b_td = 8'd90;
        @(negedge clk);
        b_tv = 1'b0;
        chk("tk_ramping", b_rmp, 1);
        chk("tk_duty", b_duty, 100);
        step_b(100, 90, "tk_step");
        chk("tk_done", b_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
